// File: rtl/apb_slave_regfile.sv
// APB completer with four word registers (CTRL, DATA, SCRATCH, read-only STATUS),
// programmable wait states, error response and write/error event counters.
module apb_slave_regfile #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int WAIT_CYCLES   = 1
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [ADDRESS_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0]    PWDATA,
  input  logic [STRB_WIDTH-1:0]    PSTRB,
  output logic [DATA_WIDTH-1:0]    PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  output logic [DATA_WIDTH-1:0]    CTRL_REG
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t                   state_q,   state_d;
  logic [3:0]               wcnt_q,    wcnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q,    addr_d;
  logic                     write_q,   write_d;
  logic [DATA_WIDTH-1:0]    wdata_q,   wdata_d;
  logic [STRB_WIDTH-1:0]    strb_q,    strb_d;
  logic [DATA_WIDTH-1:0]    ctrl_q,    ctrl_d;
  logic [DATA_WIDTH-1:0]    data_q,    data_d;
  logic [DATA_WIDTH-1:0]    scratch_q, scratch_d;
  logic [15:0]              wr_cnt_q,  wr_cnt_d;
  logic [15:0]              err_cnt_q, err_cnt_d;
  logic                     pready_q,  pready_d;
  logic                     pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]    prdata_q,  prdata_d;

  logic                     setup_s;
  logic [ADDRESS_WIDTH-1:0] xfer_addr_s;
  logic                     xfer_write_s;
  logic                     xfer_err_s;
  logic [1:0]               xfer_idx_s;
  logic [DATA_WIDTH-1:0]    rdata_s;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign setup_s = PSEL && !PENABLE;

  // Transfer attributes: live bus in IDLE (zero-wait case), captured copy afterwards
  always_comb begin
    xfer_addr_s  = addr_q;
    xfer_write_s = write_q;
    if (state_q == S_IDLE) begin
      xfer_addr_s  = PADDR;
      xfer_write_s = PWRITE;
    end else begin
      xfer_addr_s  = addr_q;
      xfer_write_s = write_q;
    end
    xfer_idx_s = xfer_addr_s[3:2];
    xfer_err_s = (xfer_addr_s[1:0] != 2'b00) || (xfer_write_s && (xfer_idx_s == 2'd3));
    case (xfer_idx_s)
      2'd0:    rdata_s = ctrl_q;
      2'd1:    rdata_s = data_q;
      2'd2:    rdata_s = scratch_q;
      2'd3:    rdata_s = DATA_WIDTH'({wr_cnt_q, err_cnt_q});
      default: rdata_s = '0;
    endcase
  end

  // Transfer FSM next state, capture and wait counter
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    case (state_q)
      S_IDLE: begin
        if (setup_s) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          if (WAIT_INIT == 4'd0) begin
            state_d = S_DONE;
          end else begin
            wcnt_d  = WAIT_INIT;
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          state_d = S_IDLE;
          wcnt_d  = 4'd0;
        end else if (wcnt_q <= 4'd1) begin
          state_d = S_DONE;
          wcnt_d  = 4'd0;
        end else begin
          wcnt_d  = wcnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Response outputs are prepared one edge ahead so they are valid throughout DONE
  always_comb begin
    pready_d  = (state_d == S_DONE);
    pslverr_d = 1'b0;
    prdata_d  = '0;
    if (pready_d) begin
      pslverr_d = xfer_err_s;
      prdata_d  = (!xfer_write_s && !xfer_err_s) ? rdata_s : '0;
    end else begin
      pslverr_d = 1'b0;
      prdata_d  = '0;
    end
  end

  // Register and counter commit at the edge that closes DONE
  always_comb begin
    ctrl_d    = ctrl_q;
    data_d    = data_q;
    scratch_d = scratch_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    if (state_q == S_DONE) begin
      if (xfer_err_s) begin
        err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
      end else if (write_q) begin
        wr_cnt_d = wr_cnt_q + 16'd1;
        case (addr_q[3:2])
          2'd0:    ctrl_d    = merge_lanes(ctrl_q, wdata_q, strb_q);
          2'd1:    data_d    = merge_lanes(data_q, wdata_q, strb_q);
          2'd2:    scratch_d = merge_lanes(scratch_q, wdata_q, strb_q);
          default: ctrl_d    = ctrl_q;
        endcase
      end else begin
        wr_cnt_d = wr_cnt_q;
      end
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
  end

  // State, capture, register file and output flops
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      wcnt_q    <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      ctrl_q    <= '0;
      data_q    <= '0;
      scratch_q <= '0;
      wr_cnt_q  <= 16'd0;
      err_cnt_q <= 16'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      ctrl_q    <= ctrl_d;
      data_q    <= data_d;
      scratch_q <= scratch_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign PREADY   = pready_q;
  assign PSLVERR  = pslverr_q;
  assign PRDATA   = prdata_q;
  assign CTRL_REG = ctrl_q;

endmodule
